// File: rtl/keypad_scan_debounce_pkg.sv
// Shared types and helpers for the keypad scanner: FSM state type plus
// small one-hot utilities used when sampling the row sense lines.
package keypad_pkg;

  // Widest row vector the helpers accept; callers zero-extend into it.
  localparam int unsigned MAX_ROWS = 32;

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    DEBOUNCE = 3'd1,
    EMIT     = 3'd2,
    HOLD     = 3'd3,
    RELEASE  = 3'd4
  } kp_state_e;

  function automatic int unsigned onehot_to_index(input logic [MAX_ROWS-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_ROWS; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic at_most_one(input logic [MAX_ROWS-1:0] v);
    return (v & (v - MAX_ROWS'(1))) == '0;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// Keypad matrix scanner: column scan, press/release debounce, chord
// rejection, optional auto-repeat and a shift history of accepted codes.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500,
  parameter int unsigned REPEAT_CYCLES   = 0,
  parameter int unsigned DIGITS          = 2
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [ROWS-1:0]                          row_in,
  output logic [COLS-1:0]                          col_drive,
  output logic                                     key_valid,
  output logic [$clog2(ROWS*COLS)-1:0]             key_code,
  output logic                                     key_held,
  output logic [DIGITS*$clog2(ROWS*COLS)-1:0]      history
);

  localparam int unsigned KW      = $clog2(ROWS * COLS);
  localparam int unsigned HW      = DIGITS * KW;
  localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CLW     = $clog2(COLS);
  localparam int unsigned CNT_MAX = max3(SETTLE_CYCLES, DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]  DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  REP_LAST    = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [CLW-1:0] COL_LAST    = CLW'(COLS - 1);

  kp_state_e       state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [CLW-1:0]  col_idx, col_nx, col_next;
  logic [RW-1:0]   row_idx, row_nx, sample_idx;
  logic [ROWS-1:0] rows_s, row_mask;
  logic            rows_single;
  logic            held_nx;
  logic [KW-1:0]   new_code;

  sync2 #(.WIDTH(ROWS)) u_row_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (row_in),
    .q       (rows_s)
  );

  assign row_mask    = ROWS'(1) << row_idx;
  assign rows_single = (rows_s != '0) && at_most_one(MAX_ROWS'(rows_s));
  assign sample_idx  = RW'(onehot_to_index(MAX_ROWS'(rows_s)));
  assign col_next    = (col_idx == COL_LAST) ? '0 : col_idx + CLW'(1);
  assign new_code    = KW'(32'(row_idx) * COLS + 32'(col_idx));

  assign col_drive = COLS'(1) << col_idx;
  assign key_valid = (state == EMIT);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    col_nx   = col_idx;
    row_nx   = row_idx;
    held_nx  = key_held;
    unique case (state)
      SCAN: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nx = '0;
          if (rows_single) begin
            state_nx = DEBOUNCE;
            row_nx   = sample_idx;
          end else begin
            col_nx = col_next;
          end
        end
      end
      DEBOUNCE: begin
        if (rows_s != row_mask) begin
          state_nx = SCAN;
          cnt_nx   = '0;
          col_nx   = col_next;
        end else if (cnt == DEB_LAST) begin
          state_nx = EMIT;
          cnt_nx   = '0;
        end
      end
      EMIT: begin
        state_nx = HOLD;
        cnt_nx   = '0;
      end
      HOLD: begin
        // The repeat counter parks at its last value while extra rows are
        // present, so the repeat fires as soon as the chord clears.
        cnt_nx = cnt;
        if (!rows_s[row_idx]) begin
          state_nx = RELEASE;
          cnt_nx   = '0;
        end else if ((REPEAT_CYCLES > 0) && (cnt == REP_LAST)) begin
          if (rows_s == row_mask) begin
            state_nx = EMIT;
            cnt_nx   = '0;
          end
        end else if (REPEAT_CYCLES > 0) begin
          cnt_nx = cnt + CW'(1);
        end
      end
      RELEASE: begin
        if (rows_s[row_idx]) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nx = SCAN;
          cnt_nx   = '0;
          col_nx   = col_next;
          held_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = SCAN;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= SCAN;
      cnt      <= '0;
      col_idx  <= '0;
      row_idx  <= '0;
      key_code <= '0;
      key_held <= 1'b0;
      history  <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      col_idx  <= col_nx;
      row_idx  <= row_nx;
      key_held <= held_nx;
      if (state_nx == EMIT) begin
        key_code <= new_code;
        key_held <= 1'b1;
        history  <= HW'({history, new_code});
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Randomised and directed bench for keypad_scan_debounce against a
// countdown-timer reference model of the scan/debounce rules.
module tb_keypad_scan_debounce;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int SETTLE = 4;
  localparam int DEB    = 20;
  localparam int REP    = 50;
  localparam int DIG    = 3;
  localparam int KW     = 4;

  localparam int M_SCAN = 0;
  localparam int M_DEB  = 1;
  localparam int M_EMIT = 2;
  localparam int M_HOLD = 3;
  localparam int M_REL  = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [ROWS-1:0]     row_in;
  logic [COLS-1:0]     col_drive;
  logic                key_valid;
  logic [KW-1:0]       key_code;
  logic                key_held;
  logic [DIG*KW-1:0]   history;

  logic [COLS-1:0]     pressed [ROWS];

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  keypad_scan_debounce #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .SETTLE_CYCLES   (SETTLE),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_CYCLES   (REP),
    .DIGITS          (DIG)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .row_in    (row_in),
    .col_drive (col_drive),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .history   (history)
  );

  // Switch matrix: a row senses high when any pressed key sits on a driven column.
  always_comb begin
    for (int r = 0; r < ROWS; r++) row_in[r] = |(pressed[r] & col_drive);
  end

  // Reference model: plain countdown timers over the synchronised rows.
  int              m_mode = M_SCAN;
  int              m_left = SETTLE;
  int              m_col  = 0;
  int              m_row  = 0;
  int              m_code = 0;
  bit              m_held = 1'b0;
  int              m_hist [DIG];
  logic [ROWS-1:0] m_s1 = '0;
  logic [ROWS-1:0] m_s2 = '0;

  task automatic model_reset();
    m_mode = M_SCAN; m_left = SETTLE; m_col = 0; m_row = 0;
    m_code = 0; m_held = 1'b0; m_s1 = '0; m_s2 = '0;
    for (int i = 0; i < DIG; i++) m_hist[i] = 0;
  endtask

  task automatic model_emit();
    m_mode = M_EMIT;
    m_code = m_row * COLS + m_col;
    for (int i = DIG - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = m_code;
    m_held = 1'b1;
  endtask

  task automatic model_step();
    logic [ROWS-1:0] seen, one, pins;
    int nxt;
    seen = m_s2;
    one  = ROWS'(1) << m_row;
    nxt  = (m_col + 1) % COLS;
    for (int r = 0; r < ROWS; r++) pins[r] = pressed[r][m_col];
    case (m_mode)
      M_SCAN:
        if (m_left == 1) begin
          if ($countones(seen) == 1) begin
            for (int r = 0; r < ROWS; r++) if (seen[r]) m_row = r;
            m_mode = M_DEB; m_left = DEB;
          end else begin
            m_col = nxt; m_left = SETTLE;
          end
        end else m_left--;
      M_DEB:
        if (seen != one) begin
          m_mode = M_SCAN; m_col = nxt; m_left = SETTLE;
        end else if (m_left == 1) model_emit();
        else m_left--;
      M_EMIT: begin
        m_mode = M_HOLD; m_left = REP;
      end
      M_HOLD:
        if (!seen[m_row]) begin
          m_mode = M_REL; m_left = DEB;
        end else if (REP > 0 && m_left == 1) begin
          if (seen == one) model_emit();
        end else if (m_left > 1) m_left--;
      M_REL:
        if (seen[m_row]) begin
          m_mode = M_HOLD; m_left = REP;
        end else if (m_left == 1) begin
          m_mode = M_SCAN; m_col = nxt; m_left = SETTLE; m_held = 1'b0;
        end else m_left--;
      default: model_reset();
    endcase
    m_s2 = m_s1;
    m_s1 = pins;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DIG*KW-1:0] model_history();
    logic [DIG*KW-1:0] h;
    for (int i = 0; i < DIG; i++) h[i*KW +: KW] = KW'(m_hist[i]);
    return h;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      check("col_drive", 64'(col_drive), 64'(COLS'(1) << m_col));
      check("key_valid", 64'(key_valid), 64'(m_mode == M_EMIT));
      check("key_code",  64'(key_code),  64'(m_code));
      check("key_held",  64'(key_held),  64'(m_held));
      check("history",   64'(history),   64'(model_history()));
    end
  end

  task automatic wait_valid(input int max, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!key_valid && k < max);
    if (!key_valid) k = -1;
  endtask

  task automatic wait_drop(input int max, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (key_held && k < max);
    if (key_held) k = -1;
  endtask

  task automatic release_all();
    for (int r = 0; r < ROWS; r++) pressed[r] = '0;
  endtask

  initial begin
    int k, n, key, code;
    int seq [4] = '{1, 2, 3, 4};
    release_all();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    check("rst_col",   64'(col_drive), 64'(1));
    check("rst_valid", 64'(key_valid), 64'(0));
    check("rst_code",  64'(key_code),  64'(0));
    check("rst_held",  64'(key_held),  64'(0));
    check("rst_hist",  64'(history),   64'(0));

    // Reset asserted while a press is being debounced.
    pressed[1][1] = 1'b1;
    reset_n = 1'b1;
    k = 0;
    while (m_mode != M_DEB && k < 200) begin
      @(negedge clk);
      k++;
    end
    reset_n = 1'b0;
    @(negedge clk);
    check("rdeb_col",   64'(col_drive), 64'(1));
    check("rdeb_valid", 64'(key_valid), 64'(0));
    check("rdeb_held",  64'(key_held),  64'(0));
    check("rdeb_hist",  64'(history),   64'(0));

    // Steady press of row 2 col 1 from reset release: strobe 28 cycles later.
    pressed[1][1] = 1'b0;
    pressed[2][1] = 1'b1;
    reset_n = 1'b1;
    wait_valid(200, k);
    check("t1_latency", 64'(k), 64'(28));
    check("t1_code",    64'(key_code), 64'(9));
    check("t1_hist",    64'(history), 64'(12'h009));
    wait_valid(200, k);
    check("t1_repeat_gap", 64'(k), 64'(REP + 1));
    check("t1_repeat_code", 64'(key_code), 64'(9));
    pressed[2][1] = 1'b0;
    wait_drop(200, k);
    check("t1_release_len", 64'(k), 64'(DEB + 3));

    // Bouncing contact on row 0 col 3, then a stable hold.
    n = 0;
    for (int i = 0; i < 20; i++) begin
      pressed[0][3] = ~pressed[0][3];
      repeat (4) begin
        @(negedge clk);
        if (key_valid) n++;
      end
    end
    check("bounce_strobes", 64'(n), 64'(0));
    pressed[0][3] = 1'b1;
    wait_valid(300, k);
    check("bounce_after_stable", 64'(k > DEB), 64'(1));
    check("bounce_code", 64'(key_code), 64'(3));
    pressed[0][3] = 1'b0;
    wait_drop(200, k);
    check("bounce_drop", 64'(key_held), 64'(0));

    // Chord on column 0 is ignored until it resolves to a single key.
    pressed[1][0] = 1'b1;
    pressed[2][0] = 1'b1;
    n = 0;
    repeat (150) begin
      @(negedge clk);
      if (key_valid) n++;
    end
    check("chord_strobes", 64'(n), 64'(0));
    pressed[2][0] = 1'b0;
    wait_valid(300, k);
    check("chord_seen", 64'(key_valid), 64'(1));
    check("chord_code", 64'(key_code), 64'(4));
    release_all();
    wait_drop(200, k);

    // History depth: four presses leave the last three codes.
    foreach (seq[i]) begin
      pressed[seq[i] / COLS][seq[i] % COLS] = 1'b1;
      wait_valid(300, k);
      check("hist_press_code", 64'(key_code), 64'(seq[i]));
      release_all();
      wait_drop(200, k);
    end
    check("hist_234", 64'(history), 64'(12'h234));

    // Random presses, bounces, chords and occasional resets.
    for (int t = 0; t < 40; t++) begin
      key = $urandom_range(0, ROWS * COLS - 1);
      n = $urandom_range(0, 6);
      for (int b = 0; b < n; b++) begin
        pressed[key / COLS][key % COLS] = ~pressed[key / COLS][key % COLS];
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      pressed[key / COLS][key % COLS] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        code = $urandom_range(0, ROWS * COLS - 1);
        pressed[code / COLS][code % COLS] = 1'b1;
      end
      repeat ($urandom_range(5, 180)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
      release_all();
      n = $urandom_range(0, 3);
      for (int b = 0; b < n; b++) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        pressed[key / COLS][key % COLS] = ~pressed[key / COLS][key % COLS];
      end
      release_all();
      repeat ($urandom_range(5, 60)) @(negedge clk);
    end
    release_all();
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Parametrised keypad front end: scans a ROWS×COLS switch matrix one column at a time, debounces press and release, rejects multi-key chords, and emits one-cycle key strobes with a linear key code. Optional auto-repeat while a key is held. Keeps a DIGITS-deep shift history of accepted codes for the display path. It sits between the keypad pins and the display mux, and replaces the fixed 4×4 two-digit debouncer.

## Interface
- ROWS, 4: matrix rows (sense inputs); ≥1.
- COLS, 4: matrix columns (drive outputs); ≥2.
- SETTLE_CYCLES, 4: cycles each column is driven before rows are sampled; ≥1.
- DEBOUNCE_CYCLES, 500: stable cycles required for press and for release; ≥1.
- REPEAT_CYCLES, 0: auto-repeat period while held; 0 disables repeat.
- DIGITS, 2: depth of code history; ≥1.
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  synchronous, active-low reset.
- row_in  in  ROWS  raw row sense, active-high, asynchronous to clk.
- col_drive  out  COLS  one-hot active-high column drive.
- key_valid  out  1  one-cycle strobe per accepted press or repeat.
- key_code  out  KW  row*COLS+col of the last accepted key; KW = $clog2(ROWS*COLS).
- key_held  out  1  high from the first strobe until release debounce completes.
- history  out  DIGITS*KW  accepted codes; newest in [KW-1:0], oldest in the top slice.

## Operation
- row_in passes through a 2-flop synchronizer (rows_s). All decisions use rows_s.
- States:
  - SCAN: drive the current column for SETTLE_CYCLES. On the last cycle, sample rows_s.
    - Exactly one bit set: latch row index and column, then go to DEBOUNCE.
    - Zero bits set, or two or more bits set (chord): advance the column modulo COLS and stay in SCAN.
  - DEBOUNCE: column held. Count DEBOUNCE_CYCLES. Any cycle where rows_s ≠ the latched one-hot returns to SCAN with the next column; there is no emit.
  - EMIT: one cycle. key_valid=1, key_code updated, history shifts left by KW with the new code inserted at the bottom, key_held=1. Go to HOLD.
  - HOLD: column held.
    - rows_s[latched]=0: go to RELEASE.
    - REPEAT_CYCLES>0 and the repeat counter reaches REPEAT_CYCLES-1 with rows_s still equal to the latched one-hot: return to EMIT and clear the counter.
    - Extra rows appearing during HOLD are ignored.
  - RELEASE: count DEBOUNCE_CYCLES of consecutive rows_s[latched]=0. Any 1 restarts the count and returns to HOLD. On completion, key_held=0 and go to SCAN with the next column.
- Counters are a single shared down/up counter of width $clog2(max(SETTLE,DEBOUNCE,REPEAT)+1), cleared on every state entry.
- Only one key is tracked at a time. No key-rollover.

## Timing
- Reset values: state SCAN, column 0, col_drive = 1 (bit 0), key_valid 0, key_code 0, key_held 0, history all zero, synchronizer flops 0.
- reset_n low mid-press returns everything to the reset values on the next edge. No strobe is emitted.
- Latency from a stable press in the scanned column: 2 (sync) + remaining settle + DEBOUNCE_CYCLES + 1 cycles to key_valid.
- Repeat strobes are exactly REPEAT_CYCLES+1 cycles apart (HOLD count plus EMIT).
- A release during DEBOUNCE produces no strobe and no history change.
- The column index wraps from COLS-1 to 0.
- key_code and history hold their values between strobes.

## Structure
- Package keypad_pkg holds:
  - the state enum typedef (SCAN, DEBOUNCE, EMIT, HOLD, RELEASE);
  - a function that converts a one-hot row to an index;
  - a popcount≤1 helper.
- One sub-module, sync2 (parametrised width), for the row synchronizer.
- FSM, counter and history register live in the top module.

## Test plan
- Defaults; press row 2, col 1 steadily → exactly one key_valid with key_code=9; history[3:0]=9. key_held stays high until release + 500 cycles.
- Bounce: toggle row 0 on col 3 every 100 cycles for 1000 cycles, then hold → one strobe with code 3, and only after the hold has been stable for 500 cycles.
- Chord: rows 1 and 2 asserted together on col 0 → no strobe. Drop row 2 → one strobe with code 4.
- Repeat: REPEAT_CYCLES=50, DEBOUNCE_CYCLES=10, hold key 15 for 300 cycles → first strobe, then strobes every 51 cycles; all codes are 15.
- History: DIGITS=3, press keys 1, 2, 3, 4 → history = {2,3,4} (oldest to newest); code 1 is shifted out.
- Reset: assert reset_n=0 during DEBOUNCE → next cycle col_drive=1, key_held=0, history unchanged from zero, no strobe.
